full_subtractor_reg: RTL and testbench
======================================

Name: full_subtractor_reg

Overview:
Registered full subtractor: computes A - B - BorrowIn and produces a difference and a borrow-out, with outputs captured on the clock. Used as the basic borrow-chain cell in datapath subtract/compare logic. WIDTH=1 gives the classic 1-bit full subtractor; larger WIDTH gives a ripple-borrow chain of identical 1-bit cells. A valid strobe travels alongside the data.

Parameters:
WIDTH, 1, operand width in bits (legal range 1..64); the chain is WIDTH cascaded 1-bit full-subtractor cells.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  A/B/BorrowIn are valid this cycle
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
BorrowIn  input  1  borrow into bit 0
Diff  output  WIDTH  registered difference, (A - B - BorrowIn) mod 2^WIDTH
BorrowOut  output  1  registered borrow out of the MSB cell
out_valid  output  1  Diff/BorrowOut hold the result of an accepted input

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low (rst_n). There are no asynchronous paths into the registers.
- Per-bit cell i, where b0 = BorrowIn and bi+1 = cell i borrow-out:
  - d_i = A[i] ^ B[i] ^ b_i
  - b_i+1 = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & b_i)
- BorrowOut = b_WIDTH. Equivalently, BorrowOut = 1 iff A < B + BorrowIn, treating the operands as unsigned.
- WIDTH=1 truth table, written as A B Bin -> Diff Bout:
  - 000 -> 0 0
  - 001 -> 1 1
  - 010 -> 1 1
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 0
  - 110 -> 0 0
  - 111 -> 1 1
- Latency: exactly 1 cycle. The inputs sampled at edge N appear on Diff/BorrowOut/out_valid after edge N. Full throughput: a new input can be accepted every cycle.
- The combinational chain is purely ripple. There is no internal pipelining for any WIDTH.
- When in_valid=1 at an edge: Diff and BorrowOut load the new result, and out_valid goes to 1.
- When in_valid=0 at an edge: Diff and BorrowOut hold their previous values, and out_valid goes to 0.
- Reset (rst_n=0 at an edge): Diff=0, BorrowOut=0, out_valid=0. Reset overrides in_valid asserted in the same cycle.
- Reset mid-stream: the input presented in the reset cycle is discarded. The first valid input after rst_n returns high produces out_valid one cycle later.
- Wrap-around: A - B - BorrowIn < 0 gives Diff equal to the two's-complement modulo 2^WIDTH, with BorrowOut=1.
  - Example, WIDTH=4: 0 - 0 - 1 -> Diff=4'hF, BorrowOut=1.
- Boundary cases:
  - A == B with BorrowIn=0 -> Diff=0, BorrowOut=0.
  - A == B with BorrowIn=1 -> Diff=all ones, BorrowOut=1.
  - A = max, B = 0, BorrowIn = 0 -> Diff = max, BorrowOut = 0.
- X/Z on the inputs while in_valid=0 must not corrupt the held outputs.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=1, B=0, BorrowIn=0 -> Diff=0, BorrowOut=0, out_valid=0 throughout. After release, the next valid input appears 1 cycle later.
- Exhaustive WIDTH=1: apply all 8 {A,B,BorrowIn} combinations from 000 to 111 on consecutive cycles with in_valid=1 -> each row of the truth table appears one cycle later with out_valid=1. Spot checks:
  - 001 -> Diff=1, BorrowOut=1
  - 100 -> Diff=1, BorrowOut=0
  - 111 -> Diff=1, BorrowOut=1
- Hold behaviour: load 010 (-> Diff=1, Bout=1), then in_valid=0 for 3 cycles while the inputs change to 100 -> Diff=1, BorrowOut=1 are held and out_valid=0.
- WIDTH=4 wrap-around, one cycle per vector:
  - A=0, B=0, Bin=1 -> Diff=F, Bout=1
  - A=9, B=3, Bin=1 -> Diff=5, Bout=0
  - A=3, B=9, Bin=0 -> Diff=A, Bout=1
  - A=F, B=0, Bin=0 -> Diff=F, Bout=0
- Mid-stream reset: feed a continuous valid stream and assert rst_n=0 for 1 cycle -> the outputs clear to 0 on that edge, and the input of the reset cycle never appears.
- Random WIDTH=8 run: 1000 random A/B/BorrowIn vectors with random in_valid -> the outputs match the reference model {BorrowOut,Diff} = ({1'b0,A} - {1'b0,B} - BorrowIn) with 1-cycle latency.

Source files
------------

// File: rtl/full_subtractor_reg.sv
// Registered ripple-borrow full subtractor: Diff/BorrowOut = A - B - BorrowIn,
// captured one cycle after an accepted input, with a valid strobe alongside.
module full_subtractor_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             out_valid
);

  logic [WIDTH-1:0] diff_d, diff_q;
  logic             borrow_d, borrow_q;
  logic             vld_d, vld_q;

  // Chain of identical 1-bit cells; returns {borrow out of MSB, difference}.
  function automatic logic [WIDTH:0] ripple_sub(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             bin
  );
    logic [WIDTH-1:0] d;
    logic             brw;
    brw = bin;
    d   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      d[i] = a[i] ^ b[i] ^ brw;
      brw  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    return {brw, d};
  endfunction

  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    vld_d    = 1'b0;
    // Inputs are only looked at when valid, so idle-cycle X/Z cannot reach the flops.
    if (in_valid) begin
      {borrow_d, diff_d} = ripple_sub(A, B, BorrowIn);
      vld_d              = 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      vld_q    <= vld_d;
    end
  end

  assign Diff      = diff_q;
  assign BorrowOut = borrow_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Bench for full_subtractor_reg at WIDTH=1, 4 and 8: truth tables, hold,
// reset and randomized comparison against an arithmetic reference.
module tb_full_subtractor_reg;

  logic clk = 1'b0;
  logic rst_n;

  logic       iv1, a1, b1, bi1, d1, bo1, ov1;
  logic       iv4, bi4, bo4, ov4;
  logic [3:0] a4, b4, d4;
  logic       iv8, bi8, bo8, ov8;
  logic [7:0] a8, b8, d8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_subtractor_reg #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .BorrowIn(bi1),
    .Diff(d1), .BorrowOut(bo1), .out_valid(ov1));
  full_subtractor_reg #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .A(a4), .B(b4), .BorrowIn(bi4),
    .Diff(d4), .BorrowOut(bo4), .out_valid(ov4));
  full_subtractor_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .BorrowIn(bi8),
    .Diff(d8), .BorrowOut(bo8), .out_valid(ov8));

  typedef struct {
    logic a, b, bin, diff, bout;
  } vec1_t;

  typedef struct {
    logic [3:0] a, b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec4_t;

  vec1_t tab1 [8];
  vec4_t tab4 [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one active edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] ref8;
    logic [7:0] exp_d8;
    logic       exp_b8;

    tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tab4[0] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    tab4[1] = '{4'h9, 4'h3, 1'b1, 4'h5, 1'b0};
    tab4[2] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    tab4[3] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
    tab4[4] = '{4'h6, 4'h6, 1'b0, 4'h0, 1'b0};
    tab4[5] = '{4'h6, 4'h6, 1'b1, 4'hF, 1'b1};

    // Reset held for two edges with a valid input pending.
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
    iv4 = 1'b1; a4 = 4'h1; b4 = 4'h0; bi4 = 1'b0;
    iv8 = 1'b1; a8 = 8'h01; b8 = 8'h00; bi8 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_diff1", 64'(d1), 64'(0));
      chk("rst_bout1", 64'(bo1), 64'(0));
      chk("rst_vld1", 64'(ov1), 64'(0));
      chk("rst_diff4", 64'(d4), 64'(0));
      chk("rst_vld4", 64'(ov4), 64'(0));
      chk("rst_diff8", 64'(d8), 64'(0));
      chk("rst_vld8", 64'(ov8), 64'(0));
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_diff1", 64'(d1), 64'(1));
    chk("post_rst_bout1", 64'(bo1), 64'(0));
    chk("post_rst_vld1", 64'(ov1), 64'(1));
    chk("post_rst_diff4", 64'(d4), 64'(1));
    chk("post_rst_vld8", 64'(ov8), 64'(1));

    // WIDTH=1 exhaustive truth table on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; a1 = tab1[i].a; b1 = tab1[i].b; bi1 = tab1[i].bin;
      step();
      chk($sformatf("w1_diff[%0d]", i), 64'(d1), 64'(tab1[i].diff));
      chk($sformatf("w1_bout[%0d]", i), 64'(bo1), 64'(tab1[i].bout));
      chk($sformatf("w1_vld[%0d]", i), 64'(ov1), 64'(1));
    end

    // Hold: load 010 then idle three cycles with the inputs moved to 100.
    a1 = 1'b0; b1 = 1'b1; bi1 = 1'b0; iv1 = 1'b1;
    step();
    chk("hold_load_diff", 64'(d1), 64'(1));
    chk("hold_load_bout", 64'(bo1), 64'(1));
    iv1 = 1'b0; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_diff", 64'(d1), 64'(1));
      chk("hold_bout", 64'(bo1), 64'(1));
      chk("hold_vld", 64'(ov1), 64'(0));
    end

    // WIDTH=4 wrap-around and equal-operand boundaries.
    for (int i = 0; i < 6; i++) begin
      iv4 = 1'b1; a4 = tab4[i].a; b4 = tab4[i].b; bi4 = tab4[i].bin;
      step();
      chk($sformatf("w4_diff[%0d]", i), 64'(d4), 64'(tab4[i].diff));
      chk($sformatf("w4_bout[%0d]", i), 64'(bo4), 64'(tab4[i].bout));
      chk($sformatf("w4_vld[%0d]", i), 64'(ov4), 64'(1));
    end
    iv4 = 1'b0;

    // Mid-stream reset on WIDTH=8: the reset-cycle input must never surface.
    iv8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bi8 = 1'b1;
    step();
    chk("mid_pre_diff", 64'(d8), 64'(8'h2F));
    chk("mid_pre_vld", 64'(ov8), 64'(1));
    rst_n = 1'b0; a8 = 8'h10; b8 = 8'h80; bi8 = 1'b0;
    step();
    chk("mid_rst_diff", 64'(d8), 64'(0));
    chk("mid_rst_bout", 64'(bo8), 64'(0));
    chk("mid_rst_vld", 64'(ov8), 64'(0));
    rst_n = 1'b1; iv8 = 1'b0;
    step();
    chk("mid_idle_diff", 64'(d8), 64'(0));
    chk("mid_idle_vld", 64'(ov8), 64'(0));
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b0;
    step();
    chk("mid_after_diff", 64'(d8), 64'(8'hFF));
    chk("mid_after_bout", 64'(bo8), 64'(0));
    chk("mid_after_vld", 64'(ov8), 64'(1));

    // Randomized WIDTH=8 against plain unsigned arithmetic.
    exp_d8 = 8'hFF;
    exp_b8 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      bi8 = 1'($urandom_range(0, 1));
      if (iv8) begin
        ref8   = {1'b0, a8} - {1'b0, b8} - {8'd0, bi8};
        exp_d8 = ref8[7:0];
        exp_b8 = ref8[8];
      end
      step();
      chk("rnd_diff", 64'(d8), 64'(exp_d8));
      chk("rnd_bout", 64'(bo8), 64'(exp_b8));
      chk("rnd_vld", 64'(ov8), 64'(iv8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
